// File: rtl/map_access_arbiter.sv
// Single-port access arbiter for the obstacle map RAM: editor writes, search and display reads,
// coordinate screening, and map clearing after reset or on request.
module map_access_arbiter #(
   parameter int unsigned GRID_W  = 40,
   parameter int unsigned GRID_H  = 40,
   parameter int unsigned COORD_W = 8,
   parameter int unsigned ADDR_W  = 11
) (
   input  logic               sync,
   input  logic               reset,
   input  logic               clear_req,
   output logic               clear_done,
   output logic               busy,
   input  logic               ed_req,
   input  logic [COORD_W-1:0] ed_x,
   input  logic [COORD_W-1:0] ed_y,
   input  logic               ed_wdata,
   output logic               ed_gnt,
   output logic               ed_err,
   input  logic               se_req,
   input  logic [COORD_W-1:0] se_x,
   input  logic [COORD_W-1:0] se_y,
   output logic               se_gnt,
   output logic               se_rvalid,
   output logic               se_rdata,
   input  logic               dp_req,
   input  logic [COORD_W-1:0] dp_x,
   input  logic [COORD_W-1:0] dp_y,
   output logic               dp_gnt,
   output logic               dp_rvalid,
   output logic               dp_rdata,
   output logic               ram_en,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_wdata,
   input  logic               ram_rdata
);

   localparam logic [COORD_W-1:0] GridWC   = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] GridHC   = COORD_W'(GRID_H);
   localparam logic [ADDR_W-1:0]  GridWA   = ADDR_W'(GRID_W);
   localparam logic [ADDR_W-1:0]  LastAddr = ADDR_W'(GRID_W * GRID_H - 1);

   typedef enum logic [1:0] {Start, Clear, Serve} stateT;

   stateT             state, stateNext;
   logic [ADDR_W-1:0] clrCnt, clrCntNext;
   logic              rrPtr, rrPtrNext;
   logic              clearDoneQ, clearDoneNext;
   logic              edErrQ;
   logic              seRvalidQ, seOorQ, seHeld;
   logic              dpRvalidQ, dpOorQ, dpHeld;

   logic               inServe;
   logic               edGnt, seGnt, dpGnt, anyGnt;
   logic [COORD_W-1:0] selX, selY;
   logic               inRange;
   logic [ADDR_W-1:0]  linAddr;

   // Editor always wins; rrPtr breaks ties between the two readers (0 = search first).
   assign inServe = (state == Serve);
   assign edGnt   = inServe & ed_req;
   assign seGnt   = inServe & ~ed_req & se_req & (~dp_req | ~rrPtr);
   assign dpGnt   = inServe & ~ed_req & dp_req & (~se_req | rrPtr);
   assign anyGnt  = edGnt | seGnt | dpGnt;

   always_comb begin
      selX = dp_x;
      selY = dp_y;
      if (edGnt) begin
         selX = ed_x;
         selY = ed_y;
      end else if (seGnt) begin
         selX = se_x;
         selY = se_y;
      end
   end

   // The sentinel (all ones) is always >= the grid size, so it falls out as out-of-range.
   assign inRange = (selX < GridWC) && (selY < GridHC);
   assign linAddr = ADDR_W'(selY) * GridWA + ADDR_W'(selX);

   always_comb begin
      stateNext     = state;
      clrCntNext    = clrCnt;
      rrPtrNext     = rrPtr;
      clearDoneNext = 1'b0;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      ram_wdata     = 1'b0;
      ram_addr      = '0;
      unique case (state)
         Start: begin
            clrCntNext = '0;
            stateNext  = Clear;
         end
         Clear: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clrCnt;
            if (clrCnt == LastAddr) begin
               clrCntNext    = '0;
               clearDoneNext = 1'b1;
               stateNext     = Serve;
            end else begin
               clrCntNext = clrCnt + ADDR_W'(1);
            end
         end
         Serve: begin
            if (anyGnt && inRange) begin
               ram_en    = 1'b1;
               ram_we    = edGnt;
               ram_wdata = edGnt & ed_wdata;
               ram_addr  = linAddr;
            end
            if (seGnt) rrPtrNext = 1'b1;
            if (dpGnt) rrPtrNext = 1'b0;
            if (clear_req) begin
               clrCntNext = '0;
               stateNext  = Clear;
            end
         end
         default: stateNext = Start;
      endcase
   end

   always_ff @(posedge sync or negedge reset) begin
      if (!reset) begin
         state      <= Start;
         clrCnt     <= '0;
         rrPtr      <= 1'b0;
         clearDoneQ <= 1'b0;
         edErrQ     <= 1'b0;
         seRvalidQ  <= 1'b0;
         seOorQ     <= 1'b0;
         seHeld     <= 1'b0;
         dpRvalidQ  <= 1'b0;
         dpOorQ     <= 1'b0;
         dpHeld     <= 1'b0;
      end else begin
         state      <= stateNext;
         clrCnt     <= clrCntNext;
         rrPtr      <= rrPtrNext;
         clearDoneQ <= clearDoneNext;
         edErrQ     <= edGnt & ~inRange;
         seRvalidQ  <= seGnt;
         seOorQ     <= seGnt & ~inRange;
         dpRvalidQ  <= dpGnt;
         dpOorQ     <= dpGnt & ~inRange;
         if (seRvalidQ) seHeld <= se_rdata;
         if (dpRvalidQ) dpHeld <= dp_rdata;
      end
   end

   // Read data is taken live from the RAM in the rvalid cycle, then held until the next one.
   assign se_rdata   = seRvalidQ ? (seOorQ | ram_rdata) : seHeld;
   assign dp_rdata   = dpRvalidQ ? (dpOorQ | ram_rdata) : dpHeld;
   assign se_rvalid  = seRvalidQ;
   assign dp_rvalid  = dpRvalidQ;
   assign ed_gnt     = edGnt;
   assign se_gnt     = seGnt;
   assign dp_gnt     = dpGnt;
   assign ed_err     = edErrQ;
   assign clear_done = clearDoneQ;
   // Gated by reset so every output is low the moment reset is asserted.
   assign busy       = reset & (state != Serve);

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed self-checking bench for map_access_arbiter with a 1-bit synchronous RAM model.
module tb_map_access_arbiter;

   logic        sync = 1'b0;
   logic        reset = 1'b0;
   logic        clear_req = 1'b0;
   logic        clear_done, busy;
   logic        ed_req = 1'b0, ed_wdata = 1'b0;
   logic [7:0]  ed_x = '0, ed_y = '0;
   logic        ed_gnt, ed_err;
   logic        se_req = 1'b0;
   logic [7:0]  se_x = '0, se_y = '0;
   logic        se_gnt, se_rvalid, se_rdata;
   logic        dp_req = 1'b0;
   logic [7:0]  dp_x = '0, dp_y = '0;
   logic        dp_gnt, dp_rvalid, dp_rdata;
   logic        ram_en, ram_we, ram_wdata;
   logic [10:0] ram_addr;
   logic        ram_rdata = 1'b0;
   logic        mem [0:2047];

   int checks = 0;
   int errors = 0;

   map_access_arbiter dut (
      .sync       (sync),
      .reset      (reset),
      .clear_req  (clear_req),
      .clear_done (clear_done),
      .busy       (busy),
      .ed_req     (ed_req),
      .ed_x       (ed_x),
      .ed_y       (ed_y),
      .ed_wdata   (ed_wdata),
      .ed_gnt     (ed_gnt),
      .ed_err     (ed_err),
      .se_req     (se_req),
      .se_x       (se_x),
      .se_y       (se_y),
      .se_gnt     (se_gnt),
      .se_rvalid  (se_rvalid),
      .se_rdata   (se_rdata),
      .dp_req     (dp_req),
      .dp_x       (dp_x),
      .dp_y       (dp_y),
      .dp_gnt     (dp_gnt),
      .dp_rvalid  (dp_rvalid),
      .dp_rdata   (dp_rdata),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #5 sync = ~sync;

   always @(posedge sync) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called right after reset is released at a falling edge; ends two cycles into SERVE.
   task automatic runClear();
      #1 chk("start", 32'({busy, ram_en, ed_gnt, se_gnt, dp_gnt, clear_done}), 32'b100000);
      for (int i = 0; i < 1600; i++) begin
         @(negedge sync);
         clear_req = (i == 800);
         #1 chk("clear", 32'({busy, ram_en, ram_we, ram_wdata, ram_addr,
                              ed_gnt, se_gnt, dp_gnt, clear_done}),
                32'({4'b1110, 11'(i), 4'b0000}));
      end
      @(negedge sync);
      clear_req = 1'b0; ed_req = 1'b0; se_req = 1'b0; dp_req = 1'b0;
      #1 chk("clear_done", 32'({clear_done, busy, ram_en}), 32'b100);
      @(negedge sync);
      #1 chk("clear_done_off", 32'({clear_done, busy}), 32'b00);
   endtask

   logic [12:0] expAlt;
   logic [1:0]  prevGnt;

   initial begin
      // Reset held: everything low.
      @(negedge sync);
      @(negedge sync);
      #1 chk("reset_outs", 32'({busy, clear_done, ed_gnt, ed_err, se_gnt, se_rvalid, se_rdata,
                                dp_gnt, dp_rvalid, dp_rdata, ram_en, ram_we, ram_wdata, ram_addr}),
             32'd0);

      // Release with every requester asking; nothing may be granted while clearing.
      @(negedge sync);
      reset = 1'b1;
      ed_req = 1'b1; ed_x = 8'd3; ed_y = 8'd2; ed_wdata = 1'b1;
      se_req = 1'b1; dp_req = 1'b1;
      runClear();

      // Editor write (3,2)=1, then search read of the same cell.
      @(negedge sync);
      ed_req = 1'b1; ed_x = 8'd3; ed_y = 8'd2; ed_wdata = 1'b1;
      #1 chk("ed_write", 32'({ed_gnt, se_gnt, dp_gnt, ram_en, ram_we, ram_wdata, ram_addr}),
             32'({6'b100111, 11'd83}));
      @(negedge sync);
      ed_req = 1'b0; se_req = 1'b1; se_x = 8'd3; se_y = 8'd2;
      #1 chk("se_read", 32'({ed_gnt, se_gnt, dp_gnt, ram_en, ram_we, ram_addr}),
             32'({5'b01010, 11'd83}));
      chk("no_ed_err", 32'(ed_err), 32'd0);
      @(negedge sync);
      se_req = 1'b0; dp_req = 1'b1; dp_x = 8'd4; dp_y = 8'd2;
      #1 chk("se_rvalid", 32'({se_rvalid, se_rdata}), 32'b11);
      chk("dp_read", 32'({dp_gnt, ram_en, ram_we, ram_addr}), 32'({3'b110, 11'd84}));
      @(negedge sync);
      dp_req = 1'b0;
      #1 chk("dp_rvalid", 32'({dp_rvalid, dp_rdata, se_rvalid, se_rdata}), 32'b1001);

      // Both readers asking continuously: se, dp, se, dp.
      se_x = 8'd0; se_y = 8'd0; dp_x = 8'd39; dp_y = 8'd39;
      prevGnt = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(negedge sync);
         se_req = 1'b1; dp_req = 1'b1;
         expAlt = (k % 2 == 0) ? {2'b10, 11'd0} : {2'b01, 11'd1599};
         #1 chk("alternate", 32'({se_gnt, dp_gnt, ram_addr}), 32'(expAlt));
         chk("alt_rvalid", 32'({se_rvalid, dp_rvalid}), 32'(prevGnt));
         prevGnt = expAlt[12:11];
      end
      @(negedge sync);
      se_req = 1'b0; dp_req = 1'b0;
      #1 chk("alt_last", 32'({se_rvalid, dp_rvalid, dp_rdata}), 32'b010);

      // All three asking: editor wins every cycle, round-robin pointer untouched.
      for (int k = 0; k < 3; k++) begin
         @(negedge sync);
         ed_req = 1'b1; ed_x = 8'd5; ed_y = 8'd5; ed_wdata = 1'b1;
         se_req = 1'b1; se_x = 8'd0; se_y = 8'd0;
         dp_req = 1'b1; dp_x = 8'd1; dp_y = 8'd0;
         #1 chk("ed_priority", 32'({ed_gnt, se_gnt, dp_gnt, ram_we, ram_addr}),
                32'({4'b1001, 11'd205}));
      end
      @(negedge sync);
      ed_req = 1'b0;
      #1 chk("after_ed_se", 32'({ed_gnt, se_gnt, dp_gnt, ram_addr}), 32'({3'b010, 11'd0}));
      @(negedge sync);
      se_req = 1'b0;
      #1 chk("after_ed_dp", 32'({dp_gnt, ram_addr}), 32'({1'b1, 11'd1}));
      chk("se_free_cell", 32'({se_rvalid, se_rdata}), 32'b10);

      // Out-of-range: sentinel read, x past edge read, y past edge write.
      @(negedge sync);
      dp_req = 1'b0; se_req = 1'b1; se_x = 8'hFF; se_y = 8'hFF;
      #1 chk("se_oor_gnt", 32'({se_gnt, ram_en}), 32'b10);
      chk("dp_free_cell", 32'({dp_rvalid, dp_rdata}), 32'b10);
      @(negedge sync);
      se_req = 1'b0; dp_req = 1'b1; dp_x = 8'd40; dp_y = 8'd0;
      #1 chk("dp_oor_gnt", 32'({dp_gnt, ram_en}), 32'b10);
      chk("se_oor_data", 32'({se_rvalid, se_rdata}), 32'b11);
      @(negedge sync);
      dp_req = 1'b0; ed_req = 1'b1; ed_x = 8'd0; ed_y = 8'd40; ed_wdata = 1'b1;
      #1 chk("ed_oor_gnt", 32'({ed_gnt, ram_en, ed_err}), 32'b100);
      chk("dp_oor_data", 32'({dp_rvalid, dp_rdata}), 32'b11);
      @(negedge sync);
      ed_req = 1'b0;
      #1 chk("ed_err_pulse", 32'({ed_err, ram_en}), 32'b10);
      @(negedge sync);
      #1 chk("ed_err_off", 32'(ed_err), 32'd0);

      // clear_req in SERVE with a read in flight.
      @(negedge sync);
      se_req = 1'b1; se_x = 8'd5; se_y = 8'd5; clear_req = 1'b1;
      #1 chk("clr_gnt", 32'({busy, se_gnt, ram_en, ram_we, ram_addr}), 32'({4'b0110, 11'd205}));
      @(negedge sync);
      se_req = 1'b0; clear_req = 1'b0;
      #1 chk("clr_rvalid", 32'({se_rvalid, se_rdata}), 32'b11);
      chk("clr_first", 32'({busy, se_gnt, ram_en, ram_we, ram_addr}), 32'({4'b1011, 11'd0}));
      for (int k = 1; k < 4; k++) begin
         @(negedge sync);
         se_req = 1'b1;
         #1 chk("clr_run", 32'({busy, se_gnt, ram_en, ram_addr}), 32'({3'b101, 11'(k)}));
      end

      // Reset mid-clear: outputs drop at once, then START and a full clear from 0.
      @(negedge sync);
      reset = 1'b0;
      #1 chk("reset_mid", 32'({busy, clear_done, ed_gnt, ed_err, se_gnt, se_rvalid, se_rdata,
                               dp_gnt, dp_rvalid, dp_rdata, ram_en, ram_we, ram_wdata, ram_addr}),
             32'd0);
      @(negedge sync);
      reset = 1'b1;
      ed_req = 1'b1; ed_x = 8'd3; ed_y = 8'd2; ed_wdata = 1'b1; dp_req = 1'b1;
      runClear();

      // Previously written cells read back as free; pointer restarted at search.
      @(negedge sync);
      se_req = 1'b1; se_x = 8'd3; se_y = 8'd2;
      dp_req = 1'b1; dp_x = 8'd5; dp_y = 8'd5;
      #1 chk("post_se_gnt", 32'({se_gnt, dp_gnt, ram_addr}), 32'({2'b10, 11'd83}));
      @(negedge sync);
      se_req = 1'b0;
      #1 chk("post_dp_gnt", 32'({se_gnt, dp_gnt, ram_addr}), 32'({2'b01, 11'd205}));
      chk("post_se_data", 32'({se_rvalid, se_rdata}), 32'b10);
      @(negedge sync);
      dp_req = 1'b0;
      #1 chk("post_dp_data", 32'({dp_rvalid, dp_rdata}), 32'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/map_access_arbiter.md
# map_access_arbiter

Arbitrates single-port access to the 40x40 obstacle map RAM among three requesters: map editor (writes), A* search engine (neighbor obstacle reads), and display renderer (grid reads). It converts (x,y) coordinates to a linear RAM address, screens out-of-range coordinates including the 0xFF "no node" sentinel, and issues at most one RAM operation per cycle. It also owns map initialisation: the map is cleared to all-free after reset and on request.

## Interface
- GRID_W, 40, map width in cells
- GRID_H, 40, map height in cells
- COORD_W, 8, coordinate width; all-ones is the sentinel
- ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= GRID_W*GRID_H
- sync  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear_req  in  1  one-cycle pulse; start a full map clear
- clear_done  out  1  one-cycle pulse when a clear completes
- busy  out  1  high while clearing
- ed_req / ed_x / ed_y / ed_wdata  in  1/COORD_W/COORD_W/1  editor write request; 1 = obstacle
- ed_gnt  out  1  editor grant
- ed_err  out  1  one-cycle pulse when a granted write is out of range (write dropped)
- se_req / se_x / se_y  in  1/COORD_W/COORD_W  search read request
- se_gnt, se_rvalid, se_rdata  out  1 each  search grant, read valid, obstacle bit
- dp_req / dp_x / dp_y  in  1/COORD_W/COORD_W  display read request
- dp_gnt, dp_rvalid, dp_rdata  out  1 each  display grant, read valid, obstacle bit
- ram_en, ram_we  out  1 each  RAM enable and write enable
- ram_addr  out  ADDR_W  linear address = y*GRID_W + x
- ram_wdata  out  1  RAM write data
- ram_rdata  in  1  RAM read data, valid one cycle after ram_en with ram_we=0

## Operation
- States: START, CLEAR, SERVE. reset low forces START, clear counter 0, rr_ptr 0, and every output 0.
- START: one cycle, then CLEAR. busy=1 from START onward.
- CLEAR: ram_en=1, ram_we=1, ram_wdata=0, ram_addr=counter; counter increments each cycle. After the write to GRID_W*GRID_H-1, go to SERVE, pulse clear_done, drop busy. No grants are issued in START or CLEAR. clear_req is ignored in START and CLEAR.
- SERVE: grants are combinational from the *_req inputs and registered state. At most one gnt is high per cycle.
  - Editor has the highest priority.
  - Search vs display: round-robin on rr_ptr (0 = search preferred). rr_ptr toggles to favour the other requester after each se_gnt or dp_gnt.
  - A single requester is always granted when it is the only one asking.
- Granted in-range request: ram_en=1; ram_we=1 for the editor, 0 for reads; ram_addr is computed in the same cycle.
- Out-of-range request (x>=GRID_W or y>=GRID_H, including sentinel 0xFF):
  - Still granted, but ram_en=0.
  - Reads return rdata=1, so the cell is treated as an obstacle.
  - Writes are dropped and ed_err pulses in the next cycle.
- clear_req high in SERVE: the current cycle's grant still completes. The next state is CLEAR with counter 0, and busy rises in that next cycle.
- Address arithmetic is unsigned, ADDR_W bits, and computed only for in-range coordinates, so there is no wrap-around.

## Timing
- A requester holds req, x, y and wdata stable until it samples gnt=1 at a rising edge. Afterwards it may deassert req or present a new request in the following cycle. Back-to-back grants to the same requester are allowed.
- Read latency: rvalid pulses exactly one cycle after gnt. rdata is ram_rdata, or 1 for out-of-range, and is held until the next rvalid.
- A read granted in the final SERVE cycle before CLEAR still returns rvalid one cycle later.
- Clear duration: 1 START cycle plus GRID_W*GRID_H CLEAR cycles (1601 with defaults). clear_done is coincident with the first SERVE cycle.
- Worst-case read wait with the editor idle: 1 cycle.

## Test plan
- Reset release -> busy=1 for 1601 cycles; ram_addr runs 0..1599 with ram_we=1 and ram_wdata=0; clear_done pulses once; no gnt during this period.
- Editor writes (3,2)=1, then search reads (3,2) -> ram_addr=83; se_gnt in the read cycle; se_rvalid=1 and se_rdata=1 next cycle.
- se_req and dp_req held continuously, editor idle -> grants alternate se, dp, se, dp..., starting with se after reset.
- ed_req, se_req and dp_req all high for 3 cycles -> ed_gnt each cycle; se_gnt and dp_gnt stay 0.
- search reads (0xFF,0xFF) and display reads (40,0) -> granted with ram_en=0, rdata=1; editor write to (0,40) -> ed_err pulse, no RAM write.
- clear_req in SERVE while se_req is active; also reset asserted mid-CLEAR -> the granted read still returns rvalid, then CLEAR restarts at address 0; in the reset case all outputs go to 0 immediately and START follows the release.
